// File: rtl/rv_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_queue
// Purpose  : RV instruction decode stage followed by a DEPTH-entry queue of
//            decoded instructions. Fetched words enter over in_valid/in_ready,
//            are decoded combinationally and stored at the tail. The head is
//            offered to execute over out_valid/out_ready.
// Ports    : clk, rst_n (synchronous, active-low)
//            in_valid/in_ready/in_inst/in_pc : fetch side handshake + payload
//            flush                           : drop every queued entry
//            out_valid/out_ready/out_*       : head entry handshake + payload
//            count                           : queue occupancy
// Options  : RV_M_EXT_EN - when defined, decode the M extension
//            (mul/mulh/div/divu/rem/remu); otherwise those encodings are
//            flagged illegal.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [2:0]               out_type,
  output logic                     out_rd_wr,
  output logic                     out_rd_mem_alu,
  output logic                     out_mem_wr,
  output logic                     out_pc_normal,
  output logic [3:0]               out_alu_control,
  output logic [1:0]               out_alu_src1_key,
  output logic [1:0]               out_alu_src2_key,
  output logic [2:0]               out_pc_control,
  output logic [2:0]               out_mem_bits,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [2:0] T_I = 3'b000, T_U = 3'b001, T_S = 3'b010, T_J = 3'b011,
                         T_R = 3'b100, T_B = 3'b101, T_N = 3'b111;

  localparam logic [6:0] OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_IMM    = 7'b0010011, OP_LOAD  = 7'b0000011,
                         OP_JALR   = 7'b1100111, OP_REG   = 7'b0110011,
                         OP_BRANCH = 7'b1100011, OP_STORE = 7'b0100011,
                         OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      itype;
    logic            rd_wr;
    logic            rd_mem_alu;
    logic            mem_wr;
    logic            pc_normal;
    logic [3:0]      alu_control;
    logic [1:0]      alu_src1_key;
    logic [1:0]      alu_src2_key;
    logic [2:0]      pc_control;
    logic [2:0]      mem_bits;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [3:0]        base_alu;
  logic [3:0]        m_alu;
  logic              m_ok;
  logic signed [31:0] imm32;
  entry_t            dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Shared funct3 map for reg-imm and reg-reg ops; inst[30] picks sra over srl.
  always_comb begin
    base_alu = 4'b0101;
    case (funct3)
      3'b000:  base_alu = 4'b0000;
      3'b001:  base_alu = 4'b0110;
      3'b010:  base_alu = 4'b0001;
      3'b011:  base_alu = 4'b0010;
      3'b100:  base_alu = 4'b0011;
      3'b101:  base_alu = in_inst[30] ? 4'b1000 : 4'b0111;
      3'b110:  base_alu = 4'b0100;
      default: base_alu = 4'b0101;
    endcase
  end

`ifdef RV_M_EXT_EN
  always_comb begin
    m_alu = 4'b0000;
    m_ok  = 1'b1;
    case (funct3)
      3'b000:  m_alu = 4'b1010;
      3'b001:  m_alu = 4'b1101;
      3'b100:  m_alu = 4'b1011;
      3'b101:  m_alu = 4'b1111;
      3'b110:  m_alu = 4'b1100;
      3'b111:  m_alu = 4'b1110;
      default: m_ok  = 1'b0;   // mulhsu/mulhu are not supported
    endcase
  end
`else
  assign m_alu = 4'b0000;
  assign m_ok  = 1'b0;
`endif

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rd        = in_inst[11:7];
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.pc_normal = 1'b1;
    dec.itype     = T_N;
    dec.illegal   = 1'b0;
    imm32         = '0;

    case (opcode)
      OP_LUI:   dec.itype = T_U;
      OP_AUIPC: begin
        dec.itype        = T_U;
        dec.alu_src1_key = 2'b01;
      end
      OP_IMM: begin
        dec.itype        = T_I;
        dec.alu_control  = base_alu;
        dec.alu_src1_key = 2'b10;
      end
      OP_LOAD: begin
        dec.itype        = T_I;
        dec.rd_mem_alu   = 1'b1;
        dec.mem_bits     = funct3;
        dec.alu_src1_key = 2'b10;
        dec.illegal      = (funct3 == 3'b111) ||
                           ((XLEN == 32) && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OP_JALR: begin
        dec.itype        = T_I;
        dec.pc_normal    = 1'b0;
        dec.pc_control   = 3'b011;
        dec.alu_src1_key = 2'b01;
        dec.alu_src2_key = 2'b10;
        dec.illegal      = (funct3 != 3'b000);
      end
      OP_REG: begin
        dec.itype        = T_R;
        dec.alu_src1_key = 2'b10;
        dec.alu_src2_key = 2'b01;
        if (funct7 == 7'b0000000)
          dec.alu_control = base_alu;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          dec.alu_control = 4'b1001;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)
          dec.alu_control = 4'b1000;
        else if (funct7 == 7'b0000001 && m_ok)
          dec.alu_control = m_alu;
        else
          dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec.itype      = T_B;
        dec.pc_normal  = 1'b0;
        dec.pc_control = funct3;
        dec.illegal    = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_STORE: begin
        dec.itype        = T_S;
        dec.mem_bits     = funct3;
        dec.alu_src1_key = 2'b10;
        dec.illegal      = (XLEN == 32) ? (funct3 > 3'b010) : (funct3 > 3'b011);
      end
      OP_JAL: begin
        dec.itype        = T_J;
        dec.pc_normal    = 1'b0;
        dec.pc_control   = 3'b010;
        dec.alu_src1_key = 2'b01;
        dec.alu_src2_key = 2'b10;
      end
      default: dec.illegal = 1'b1;   // unknown opcode -> type N
    endcase

    if (in_inst[1:0] != 2'b11)
      dec.illegal = 1'b1;

    dec.rd_wr  = (dec.itype == T_U || dec.itype == T_I ||
                  dec.itype == T_J || dec.itype == T_R) && !dec.illegal;
    dec.mem_wr = (dec.itype == T_S) && !dec.illegal;

    // Immediates are assembled at 32 bits with sign, then widened to XLEN.
    case (dec.itype)
      T_I:     imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      T_S:     imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      T_B:     imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
      T_U:     imm32 = {in_inst[31:12], 12'b0};
      T_J:     imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = XLEN'(imm32);
  end

  // --------------------------------------------------------------------------
  // Queue
  // --------------------------------------------------------------------------
  entry_t          mem [DEPTH];
  entry_t          head_entry;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            push;
  logic            pop;

  assign out_valid = (count != '0);
  assign in_ready  = (count < FULL_COUNT) && rst_n;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // push already implies rst_n; flush cancels the write.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[tail] <= dec;
  end

  assign head_entry = out_valid ? mem[head] : '0;

  assign out_pc           = head_entry.pc;
  assign out_type         = head_entry.itype;
  assign out_rd_wr        = head_entry.rd_wr;
  assign out_rd_mem_alu   = head_entry.rd_mem_alu;
  assign out_mem_wr       = head_entry.mem_wr;
  assign out_pc_normal    = head_entry.pc_normal;
  assign out_alu_control  = head_entry.alu_control;
  assign out_alu_src1_key = head_entry.alu_src1_key;
  assign out_alu_src2_key = head_entry.alu_src2_key;
  assign out_pc_control   = head_entry.pc_control;
  assign out_mem_bits     = head_entry.mem_bits;
  assign out_rd           = head_entry.rd;
  assign out_rs1          = head_entry.rs1;
  assign out_rs2          = head_entry.rs2;
  assign out_imm          = head_entry.imm;
  assign out_illegal      = head_entry.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_decode_queue
// Purpose  : Self-checking bench for rv_decode_queue. A queue-based model
//            decodes each accepted instruction from the instruction-set rules
//            and is compared against the DUT head every cycle; directed
//            literal checks pin the model. A second XLEN=64 instance covers
//            the wide immediate and 64-bit-only loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef RV_M_EXT_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [2:0]      out_type, out_pc_control, out_mem_bits;
  logic            out_rd_wr, out_rd_mem_alu, out_mem_wr, out_pc_normal, out_illegal;
  logic [3:0]      out_alu_control;
  logic [1:0]      out_alu_src1_key, out_alu_src2_key;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      count;

  rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_type(out_type),
    .out_rd_wr(out_rd_wr), .out_rd_mem_alu(out_rd_mem_alu), .out_mem_wr(out_mem_wr),
    .out_pc_normal(out_pc_normal), .out_alu_control(out_alu_control),
    .out_alu_src1_key(out_alu_src1_key), .out_alu_src2_key(out_alu_src2_key),
    .out_pc_control(out_pc_control), .out_mem_bits(out_mem_bits),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_illegal(out_illegal), .count(count)
  );

  // Wide instance: always draining, one instruction at a time.
  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [31:0] w_in_inst;
  logic [63:0] w_out_pc, w_out_imm;
  logic [2:0]  w_out_type, w_out_pc_control, w_out_mem_bits;
  logic        w_out_rd_wr, w_out_rd_mem_alu, w_out_mem_wr, w_out_pc_normal, w_out_illegal;
  logic [3:0]  w_out_alu_control;
  logic [1:0]  w_out_alu_src1_key, w_out_alu_src2_key, w_count;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;

  rv_decode_queue #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_inst(w_in_inst), .in_pc(64'h8000_0000), .flush(1'b0), .out_valid(w_out_valid),
    .out_ready(1'b1), .out_pc(w_out_pc), .out_type(w_out_type),
    .out_rd_wr(w_out_rd_wr), .out_rd_mem_alu(w_out_rd_mem_alu), .out_mem_wr(w_out_mem_wr),
    .out_pc_normal(w_out_pc_normal), .out_alu_control(w_out_alu_control),
    .out_alu_src1_key(w_out_alu_src1_key), .out_alu_src2_key(w_out_alu_src2_key),
    .out_pc_control(w_out_pc_control), .out_mem_bits(w_out_mem_bits),
    .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_imm(w_out_imm),
    .out_illegal(w_out_illegal), .count(w_count)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [2:0]      typ;
    logic [17:0]     ctrl;   // rd_wr,rd_mem_alu,mem_wr,pc_normal,alu,src1,src2,pc_ctl,mem_bits
    logic [14:0]     regs;   // rd,rs1,rs2
    logic [XLEN-1:0] imm;
    logic            ill;
  } exp_t;

  function automatic exp_t expect_of(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3, pcc, mb;
    logic [3:0] alu;
    logic [1:0] s1, s2;
    logic [3:0] rimap [8];
    logic [3:0] mmap  [8];
    bit is_lui, is_auipc, is_opi, is_ld, is_jalr, is_op, is_br, is_st, is_jal, op_ok, wr;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    rimap = '{4'h0, 4'h6, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5};
    mmap  = '{4'hA, 4'hD, 4'h0, 4'h0, 4'hB, 4'hF, 4'hC, 4'hE};
    is_lui = (op == 7'h37); is_auipc = (op == 7'h17); is_opi = (op == 7'h13);
    is_ld  = (op == 7'h03); is_jalr  = (op == 7'h67); is_op  = (op == 7'h33);
    is_br  = (op == 7'h63); is_st    = (op == 7'h23); is_jal = (op == 7'h6F);

    if (is_lui || is_auipc)              e.typ = 3'd1;
    else if (is_opi || is_ld || is_jalr) e.typ = 3'd0;
    else if (is_op)                      e.typ = 3'd4;
    else if (is_br)                      e.typ = 3'd5;
    else if (is_st)                      e.typ = 3'd2;
    else if (is_jal)                     e.typ = 3'd3;
    else                                 e.typ = 3'd7;

    op_ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
            (M_ON && f7 == 7'h01 && !(f3 inside {3'd2, 3'd3}));
    e.ill = (inst[1:0] != 2'b11) || (e.typ == 3'd7) ||
            (is_jalr && f3 != 3'd0) || (is_br && f3 inside {3'd2, 3'd3}) ||
            (is_ld && ((XLEN == 32) ? (f3 inside {3'd3, 3'd6, 3'd7}) : (f3 == 3'd7))) ||
            (is_st && f3 > ((XLEN == 32) ? 3'd2 : 3'd3)) ||
            (is_op && !op_ok);

    alu = 4'h0;
    if (is_opi) alu = (f3 == 3'd5 && inst[30]) ? 4'h8 : rimap[f3];
    if (is_op && op_ok) begin
      if (f7 == 7'h00)      alu = rimap[f3];
      else if (f7 == 7'h20) alu = (f3 == 3'd0) ? 4'h9 : 4'h8;
      else                  alu = mmap[f3];
    end
    {s1, s2} = 4'b0000;
    if (is_auipc)            {s1, s2} = 4'b0100;
    if (is_jal || is_jalr)   {s1, s2} = 4'b0110;
    if (is_ld || is_st || is_opi) {s1, s2} = 4'b1000;
    if (is_op)               {s1, s2} = 4'b1001;

    pcc = is_br ? f3 : is_jal ? 3'd2 : is_jalr ? 3'd3 : 3'd0;
    mb  = (is_ld || is_st) ? f3 : 3'd0;
    wr  = (e.typ inside {3'd0, 3'd1, 3'd3, 3'd4}) && !e.ill;
    e.ctrl = {wr, is_ld, is_st && !e.ill, !(is_br || is_jal || is_jalr), alu, s1, s2, pcc, mb};
    e.regs = {inst[11:7], inst[19:15], inst[24:20]};
    e.pc   = pc;
    case (e.typ)
      3'd0:    e.imm = XLEN'($signed(inst[31:20]));
      3'd2:    e.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      3'd5:    e.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      3'd1:    e.imm = XLEN'($signed({inst[31:12], 12'b0}));
      3'd3:    e.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  exp_t q[$];

  always @(posedge clk) begin
    bit can_push;
    bit do_pop;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      can_push = (q.size() < DEPTH);
      do_pop   = (q.size() > 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (in_valid && can_push) q.push_back(expect_of(in_inst, in_pc));
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("count", 64'(count), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && rst_n));
      if (q.size() != 0) begin
        check("head_pc",   64'(out_pc), 64'(q[0].pc));
        check("head_type", 64'(out_type), 64'(q[0].typ));
        check("head_ctrl", 64'({out_rd_wr, out_rd_mem_alu, out_mem_wr, out_pc_normal,
                                out_alu_control, out_alu_src1_key, out_alu_src2_key,
                                out_pc_control, out_mem_bits}), 64'(q[0].ctrl));
        check("head_regs", 64'({out_rd, out_rs1, out_rs2}), 64'(q[0].regs));
        check("head_imm",  64'(out_imm), 64'(q[0].imm));
        check("head_illegal", 64'(out_illegal), 64'(q[0].ill));
      end else begin
        check("idle_payload", 64'({out_pc, out_type, out_rd_wr, out_rd_mem_alu, out_mem_wr,
                                   out_pc_normal, out_alu_control, out_alu_src1_key,
                                   out_alu_src2_key, out_pc_control, out_mem_bits,
                                   out_rd, out_rs1, out_rs2, out_illegal} != '0) |
                                   64'(out_imm != '0), 64'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] tab [16] = '{
    32'hFFF00093, 32'h00001297, 32'h0020A423, 32'hFE208EE3,  // addi, auipc, sw, beq
    32'h008000EF, 32'h00412203, 32'h402081B3, 32'h4030D093,  // jal, lw, sub, srai
    32'h022081B3, 32'h00000000, 32'h000010E7, 32'h0000B083,  // mul, zero, jalr f3=1, ld
    32'h00000001, 32'h202081B3, 32'h0220A1B3, 32'h0020C023   // 16-bit, bad f7, mulhsu, sb f3=4
  };
  logic [XLEN-1:0] next_pc = 32'h1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = next_pc;
    next_pc  = next_pc + 4;
  endtask

  task automatic push1(input logic [31:0] inst);
    step(); offer(inst);
    step(); in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop1();
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_inst = '0;
    @(posedge clk); @(posedge clk); #1;
    checking = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    step(); rst_n = 1'b1;

    // addi x1,x0,-1
    push1(32'hFFF00093);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_type", 64'(out_type), 64'd0);
    check("addi_alu", 64'(out_alu_control), 64'd0);
    check("addi_src", 64'({out_alu_src1_key, out_alu_src2_key}), 64'b1000);
    check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    check("addi_rd", 64'({out_rd, out_rd_wr}), 64'({5'd1, 1'b1}));
    pop1();

    // Fill past capacity with out_ready low
    for (int i = 0; i < 5; i++) begin
      step(); offer(tab[i]);
    end
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_pc", 64'(out_pc), 64'(next_pc - 20));
    step(); out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Steady push/pop at count=2, wrapping the pointers many times
    step(); offer(tab[5]);
    step(); offer(tab[6]);
    for (int i = 0; i < 20; i++) begin
      step(); offer(tab[(i + 7) % 16]); out_ready = 1'b1;
    end
    step(); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("stream_count", 64'(count), 64'd2);

    // Flush with count=3 and a simultaneous push/pop
    step(); offer(tab[3]);
    step(); offer(tab[4]); flush = 1'b1; out_ready = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);

    // Directed decode checks
    push1(32'h022081B3);
    check("mul_alu", 64'(out_alu_control), M_ON ? 64'hA : 64'h0);
    check("mul_illegal", 64'(out_illegal), M_ON ? 64'd0 : 64'd1);
    check("mul_rd_wr", 64'(out_rd_wr), M_ON ? 64'd1 : 64'd0);
    pop1();
    push1(32'h00000000);
    check("zero_illegal", 64'({out_illegal, out_type}), 64'b1111);
    pop1();
    push1(32'h000010E7);
    check("jalr_f3_illegal", 64'({out_illegal, out_rd_wr}), 64'b10);
    pop1();
    push1(32'hFE208EE3);
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("beq_pc", 64'({out_type, out_pc_normal, out_pc_control}), 64'({3'b101, 1'b0, 3'b000}));
    pop1();
    push1(32'h0020A423);
    check("sw_mem", 64'({out_mem_wr, out_mem_bits, out_rd_wr}), 64'({1'b1, 3'b010, 1'b0}));
    check("sw_imm", 64'(out_imm), 64'd8);
    pop1();
    push1(32'h402081B3);
    check("sub_alu", 64'(out_alu_control), 64'h9);
    pop1();
    push1(32'h0000B083);
    check("ld32_illegal", 64'(out_illegal), 64'd1);
    pop1();
    push1(32'h800000B7);
    check("lui32_imm", 64'(out_imm), 64'h8000_0000);
    pop1();

    // XLEN=64 instance
    step(); w_in_valid = 1'b1; w_in_inst = 32'h800000B7;
    step(); w_in_valid = 1'b0;
    @(negedge clk);
    check("lui64_valid", 64'(w_out_valid), 64'd1);
    check("lui64_imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
    step(); w_in_valid = 1'b1; w_in_inst = 32'h0000B083;
    step(); w_in_valid = 1'b0;
    @(negedge clk);
    check("ld64_legal", 64'({w_out_illegal, w_out_rd_mem_alu, w_out_mem_bits}), 64'b0_1_011);

    // Reset in the middle of traffic
    step(); offer(tab[0]);
    step(); offer(tab[1]);
    step(); offer(tab[2]); rst_n = 1'b0; out_ready = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    step(); rst_n = 1'b1;
    step(); step();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
